// File: rtl/proc_pio_pkg.sv
// Shared constants for the proc_pio_irq parallel-input block: register map,
// bus data width and legal parameter ranges.
package proc_pio_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN    = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP   = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN    = 3'd4;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd5;

    localparam int WIDTH_MIN    = 1;
    localparam int WIDTH_MAX    = 32;
    localparam int SYNC_MIN     = 2;
    localparam int SYNC_MAX     = 4;
    localparam int DEBOUNCE_MIN = 1;
    localparam int DEBOUNCE_MAX = 65535;

endpackage

// File: rtl/proc_pio_irq_if.sv
// Avalon-MM slave bus bundle used by proc_pio_irq; the host side is the
// master modport.
import proc_pio_pkg::*;

interface proc_pio_irq_if;
    logic [2:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/proc_pio_debounce.sv
// Single-bit debounce filter: the output follows the input only after the
// input has disagreed with it for CYCLES consecutive clocks.
module proc_pio_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic filt
);

    logic [15:0] cnt;

    // Any cycle of agreement restarts the stability count.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (sync_in != filt) begin
            if (cnt == 16'(CYCLES - 1)) begin
                filt <= sync_in;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/proc_pio_irq.sv
// Parallel input port with edge capture and interrupt on an Avalon-MM slave.
// Optional per-bit debounce filter enabled by macro PROC_PIO_DEBOUNCE_EN.
module proc_pio_irq
    import proc_pio_pkg::*;
#(
    parameter int WIDTH           = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    proc_pio_irq_if.slave    bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX ||
        DEBOUNCE_CYCLES < DEBOUNCE_MIN || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_param
        $error("proc_pio_irq: parameter out of range");
    end

    localparam int WARM_CYCLES = SYNC_STAGES + 1;

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  sync, filt, prev;
    logic [WIDTH-1:0]  rise_en, fall_en, irq_mask, edge_cap;
    logic [WIDTH-1:0]  rise, fall, clr, cap_next, wdata;
    logic [2:0]        warm_cnt;
    logic              armed, wr;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_wdata;

    assign sync         = sync_q[SYNC_STAGES-1];
    assign armed        = (warm_cnt == 3'(WARM_CYCLES));
    assign wr           = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    // Edge detection stays disarmed until the synchroniser has refilled after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev     <= '0;
            warm_cnt <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= filt;
            if (!armed) warm_cnt <= warm_cnt + 3'd1;
        end
    end

`ifdef PROC_PIO_DEBOUNCE_EN
    for (genvar g = 0; g < WIDTH; g++) begin : g_deb
        proc_pio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .reset   (reset),
            .sync_in (sync[g]),
            .filt    (filt[g])
        );
    end
`else
    assign filt = sync;
`endif

    // A new edge overrides a simultaneous write-one-to-clear on the same bit.
    always_comb begin
        rise     = armed ? (filt & ~prev & rise_en) : '0;
        fall     = armed ? (~filt & prev & fall_en) : '0;
        clr      = (wr && bus.address == ADDR_EDGE_CAP) ? wdata : '0;
        cap_next = (edge_cap & ~clr) | rise | fall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en  <= '1;
            fall_en  <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && bus.address == ADDR_RISE_EN) rise_en  <= wdata;
            if (wr && bus.address == ADDR_FALL_EN) fall_en  <= wdata;
            if (wr && bus.address == ADDR_IRQ_MASK) irq_mask <= wdata;
            edge_cap <= cap_next;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:       rd_mux[WIDTH-1:0] = filt;
            ADDR_RISE_EN:    rd_mux[WIDTH-1:0] = rise_en;
            ADDR_IRQ_MASK:   rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP:   rd_mux[WIDTH-1:0] = edge_cap;
            ADDR_FALL_EN:    rd_mux[WIDTH-1:0] = fall_en;
            ADDR_IRQ_STATUS: rd_mux[WIDTH-1:0] = edge_cap & irq_mask;
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= rd_mux;
    end

endmodule

// File: tb/tb_proc_pio_irq.sv
// Scoreboard bench for proc_pio_irq; also exercises the debounce filter when
// built with PROC_PIO_DEBOUNCE_EN.
module tb_proc_pio_irq;
    import proc_pio_pkg::*;

    localparam int WIDTH = 5;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
`ifdef PROC_PIO_DEBOUNCE_EN
    localparam int EXTRA  = DEB;
    localparam bit DEB_ON = 1'b1;
`else
    localparam int EXTRA  = 0;
    localparam bit DEB_ON = 1'b0;
`endif
    localparam int SETTLE = SYNC + EXTRA + 4;
    localparam logic [WIDTH-1:0] ALL = '1;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    proc_pio_irq_if bus();

    proc_pio_irq #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          chk_irq;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic rd_fire = 1'b0;

    // Reference model: register contents and the settled input level.
    logic [WIDTH-1:0] m_rise, m_fall, m_mask, m_cap, m_in;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, expv);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [2:0] a);
        case (a)
            ADDR_DATA:       return 32'(m_in);
            ADDR_RISE_EN:    return 32'(m_rise);
            ADDR_IRQ_MASK:   return 32'(m_mask);
            ADDR_EDGE_CAP:   return 32'(m_cap);
            ADDR_FALL_EN:    return 32'(m_fall);
            ADDR_IRQ_STATUS: return 32'(m_cap & m_mask);
            default:         return 32'h0;
        endcase
    endfunction

    task automatic modelWrite(input logic [2:0] a, input logic [31:0] d);
        logic [WIDTH-1:0] v;
        v = d[WIDTH-1:0];
        case (a)
            ADDR_RISE_EN:  m_rise = v;
            ADDR_IRQ_MASK: m_mask = v;
            ADDR_EDGE_CAP: m_cap  = m_cap & ~v;
            ADDR_FALL_EN:  m_fall = v;
            default: ;
        endcase
    endtask

    task automatic modelInput(input logic [WIDTH-1:0] nv);
        m_cap = m_cap | (nv & ~m_in & m_rise) | (~nv & m_in & m_fall);
        m_in  = nv;
    endtask

    task automatic modelReset(input logic [WIDTH-1:0] held);
        m_rise = ALL;
        m_fall = '0;
        m_mask = '0;
        m_cap  = '0;
        if (DEB_ON) begin
            m_in = '0;
            modelInput(held);
        end else begin
            m_in = held;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        modelWrite(a, d);
    endtask

    task automatic busReadExp(input logic [2:0] a, input logic [31:0] e, input bit ci,
                              input logic ei, input string tag);
        exp_t x;
        x.data = e; x.chk_irq = ci; x.irq = ei; x.tag = tag;
        exp_q.push_back(x);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        tick();
        bus.chipselect = 1'b0;
    endtask

    task automatic busRead(input logic [2:0] a, input string tag);
        busReadExp(a, modelRead(a), 1'b1, |(m_cap & m_mask), tag);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] nv);
        in_port = nv;
        repeat (SETTLE) tick();
        modelInput(nv);
    endtask

    // Monitor: a read issued before an edge returns its data after that edge.
    always @(posedge clk) rd_fire <= bus.chipselect && bus.write_n && !reset;

    always @(negedge clk) begin
        if (rd_fire) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: read data 0x%08h with no expectation queued", bus.readdata);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput(mon_e.tag, bus.readdata, mon_e.data);
                if (mon_e.chk_irq) checkOutput({mon_e.tag, "_irq"}, 32'(irq), 32'(mon_e.irq));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        in_port        = '0;
        reset          = 1'b1;
        repeat (3) tick();
        checkOutput("reset_readdata", bus.readdata, 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        modelReset('0);
        repeat (SETTLE) tick();
        busRead(ADDR_RISE_EN, "reset_rise_en");
        busRead(ADDR_IRQ_MASK, "reset_mask");
        busRead(ADDR_FALL_EN, "reset_fall_en");
        busRead(ADDR_EDGE_CAP, "reset_cap");

        // Exact latency of capture and irq for a rising edge on bit 0.
        busWrite(ADDR_IRQ_MASK, 32'h01);
        in_port = 5'h01;
        repeat (SYNC + EXTRA) tick();
        busReadExp(ADDR_EDGE_CAP, 32'h0, 1'b1, 1'b0, "lat_cap_before");
        busReadExp(ADDR_EDGE_CAP, 32'h1, 1'b1, 1'b1, "lat_cap_at");
        modelInput(5'h01);
        repeat (SETTLE) tick();
        busRead(ADDR_IRQ_STATUS, "lat_status");
        busRead(ADDR_DATA, "lat_data");

        // Clear and new edge on bit 0 in the same cycle: the edge must win.
        applyStimulus(5'h00);
        in_port = 5'h01;
        repeat (SYNC + EXTRA) tick();
        busWrite(ADDR_EDGE_CAP, 32'h01);
        modelInput(5'h01);
        repeat (2) tick();
        busRead(ADDR_EDGE_CAP, "clr_vs_edge");
        busWrite(ADDR_EDGE_CAP, 32'h01);
        busRead(ADDR_EDGE_CAP, "clr_after");

        // Falling-only capture on bit 2, then both polarities.
        busWrite(ADDR_RISE_EN, 32'h0);
        busWrite(ADDR_FALL_EN, 32'h04);
        applyStimulus(5'h05);
        busWrite(ADDR_EDGE_CAP, 32'hFFFF_FFFF);
        busRead(ADDR_EDGE_CAP, "fall_pre");
        applyStimulus(5'h01);
        busRead(ADDR_EDGE_CAP, "fall_cap");
        applyStimulus(5'h05);
        busRead(ADDR_EDGE_CAP, "fall_no_rise");
        busWrite(ADDR_RISE_EN, 32'hFFFF_FFFF);
        busWrite(ADDR_FALL_EN, 32'hFFFF_FFFF);
        busWrite(ADDR_EDGE_CAP, 32'hFFFF_FFFF);
        applyStimulus(5'h0A);
        busRead(ADDR_EDGE_CAP, "both_edges");

        // Unmapped addresses and out-of-width write bits.
        busRead(3'd6, "addr6_read");
        busWrite(3'd6, 32'hFFFF_FFFF);
        busRead(3'd6, "addr6_after_write");
        busRead(3'd7, "addr7_read");
        busWrite(ADDR_IRQ_MASK, 32'hFFFF_FFFF);
        busRead(ADDR_IRQ_MASK, "mask_wide");
        busWrite(ADDR_DATA, 32'hFFFF_FFFF);
        busRead(ADDR_DATA, "data_ro");
        busWrite(ADDR_IRQ_STATUS, 32'h0);
        busRead(ADDR_IRQ_STATUS, "status_ro");

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    busWrite(3'($urandom_range(0, 7)), $urandom);
                2, 3:    busRead(3'($urandom_range(0, 7)), "rand_read");
                4:       applyStimulus(WIDTH'($urandom));
                default: busWrite(ADDR_EDGE_CAP, $urandom);
            endcase
        end
        for (int a = 0; a < 8; a++) busRead(3'(a), "rand_final");

`ifdef PROC_PIO_DEBOUNCE_EN
        // A 3-cycle glitch is filtered, a sustained level is captured.
        busWrite(ADDR_RISE_EN, 32'hFFFF_FFFF);
        busWrite(ADDR_FALL_EN, 32'h0);
        applyStimulus(5'h00);
        busWrite(ADDR_EDGE_CAP, 32'hFFFF_FFFF);
        in_port = 5'h02;
        repeat (3) tick();
        in_port = 5'h00;
        repeat (SETTLE) tick();
        busRead(ADDR_EDGE_CAP, "deb_glitch");
        busRead(ADDR_DATA, "deb_glitch_data");
        applyStimulus(5'h02);
        busRead(ADDR_EDGE_CAP, "deb_level");
`endif

        // Reset during a pending edge, with inputs held high through release.
        applyStimulus(5'h00);
        in_port = ALL;
        repeat (SYNC) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        modelReset(ALL);
        repeat (10) tick();
        busRead(ADDR_EDGE_CAP, "warmup_cap");
        busRead(ADDR_DATA, "warmup_data");
        busRead(ADDR_RISE_EN, "warmup_rise_en");
        busRead(ADDR_IRQ_MASK, "warmup_mask");

        tick();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_pio_irq.md
PROC_PIO_IRQ -- requirements
Module: proc_pio_irq

Interface
REQ-001 SHALL have parameter WIDTH, default 5, meaning input port width (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser depth (2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning stable-cycle count for the debounce filter (1..65535).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port address  input  3  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port in_port  input  WIDTH  asynchronous external inputs.
REQ-011 SHALL have port readdata  output  32  registered read data.
REQ-012 SHALL have port irq  output  1  registered interrupt request.

Function
REQ-013 SHALL pass each in_port bit through SYNC_STAGES flops; the last stage is "sync", and a further flop holds "prev".
REQ-014 SHALL use the register map: 0 DATA (RO, filtered input), 1 RISE_EN (RW), 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (W1C), 4 FALL_EN (RW), 5 IRQ_STATUS (RO, EDGE_CAPTURE & IRQ_MASK); addresses 6-7 read 0 and ignore writes.
REQ-015 SHALL write a register when chipselect=1 and write_n=0, using writedata[WIDTH-1:0]; bits above WIDTH are ignored on write and read as 0.
REQ-016 SHALL register readdata every cycle from the address mux, giving one-cycle read latency independent of chipselect.
REQ-017 SHALL detect rise = filt & ~prev & RISE_EN and fall = ~filt & prev & FALL_EN per bit, and set the EDGE_CAPTURE bit on the next clock.
REQ-018 SHALL clear an EDGE_CAPTURE bit on a write of 1 to address 3; when a clear and a new edge occur on the same bit in the same cycle, the bit SHALL remain set (the edge wins).
REQ-019 SHALL register irq <= |(EDGE_CAPTURE & IRQ_MASK), so irq follows the capture/mask state with one cycle of delay.
REQ-020 SHALL give latency from an in_port transition (debounce off) to the EDGE_CAPTURE bit of SYNC_STAGES+1 clocks, and to irq of SYNC_STAGES+2 clocks.
REQ-021 SHALL suppress edge detection for SYNC_STAGES+1 cycles after reset deasserts, using a warm-up counter, so that inputs already high at reset do not produce spurious captures.
REQ-022 SHALL have pulses shorter than one clock that are not sampled by the first stage produce no capture.
REQ-023 SHALL, when a bit is enabled in both RISE_EN and FALL_EN, capture edges of either polarity.

Reset
REQ-024 SHALL, on reset, clear the synchroniser, prev, EDGE_CAPTURE, IRQ_MASK, FALL_EN, readdata, irq and the debounce state, and set RISE_EN to all ones.
REQ-025 SHALL, when reset is asserted mid-operation, discard pending edges and restart the warm-up counter.

Configuration
REQ-026 SHALL, when macro PROC_PIO_DEBOUNCE_EN is defined, update filt per bit only after sync has differed from filt for DEBOUNCE_CYCLES consecutive cycles; any return to equality resets that bit's counter.
REQ-027 SHALL, when PROC_PIO_DEBOUNCE_EN is undefined, drive filt = sync directly and instantiate no debounce counters.

Structure
REQ-028 SHALL place the register address constants (DATA..IRQ_STATUS), the readdata width and the parameter range limits in shared package proc_pio_pkg.
REQ-029 SHALL implement the per-bit debounce counter as sub-module proc_pio_debounce, instantiated WIDTH times under the macro.

Verification
REQ-030 SHALL cover: WIDTH=5, SYNC_STAGES=2, debounce off, in_port 0->0x01 -> EDGE_CAPTURE=0x01 at clock 3 and irq=1 at clock 4 with IRQ_MASK=0x01.
REQ-031 SHALL cover: FALL_EN=0x04, RISE_EN=0, in_port[2] 1->0 -> EDGE_CAPTURE=0x04, and a later 0->1 leaves it unchanged.
REQ-032 SHALL cover: a write of 0x01 to address 3 in the same cycle as a new rising edge on bit 0 -> EDGE_CAPTURE[0] stays 1; a later write of 0x01 -> reads 0.
REQ-033 SHALL cover: in_port=0x1F held through reset release -> EDGE_CAPTURE=0 after 10 cycles, and DATA reads 0x1F.
REQ-034 SHALL cover: with PROC_PIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4, a 3-cycle glitch on bit 1 -> no capture, and a 6-cycle high level -> EDGE_CAPTURE=0x02.
REQ-035 SHALL cover: a read of address 6 -> readdata=0; a write of 0xFFFFFFFF to IRQ_MASK -> reads 0x1F.
